// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, then a sign-fix cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_op,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_hi_we,
  input  logic             i_lo_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [1:0]       o_state
);

  // Handshake: i_start (with i_op/i_is_signed/i_a/i_b) is accepted only on an edge where
  // o_busy is low; o_done pulses for one cycle with HI/LO already holding the result.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_q;
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_b_zero;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic [WIDTH-1:0]   w_next_acc;
  logic [WIDTH-1:0]   w_next_q;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  always_comb begin
    w_a_mag  = (i_is_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    w_b_mag  = (i_is_signed && i_b[WIDTH-1]) ? -i_b : i_b;
    w_b_zero = (i_b == '0);

    // Multiply: r_acc:r_q is the running product, r_q starts as the multiplier.
    w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

    // Divide: r_acc is the partial remainder, r_q shifts dividend out and quotient in.
    w_div_shift = {r_acc, r_q[WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, r_opnd};

    w_next_acc = '0;
    w_next_q   = '0;
    if (r_op) begin
      if (!w_div_diff[WIDTH]) begin
        w_next_acc = w_div_diff[WIDTH-1:0];
        w_next_q   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
        w_next_acc = w_div_shift[WIDTH-1:0];
        w_next_q   = {r_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_next_acc = w_mul_sum[WIDTH:1];
      w_next_q   = {w_mul_sum[0], r_q[WIDTH-1:1]};
    end

    w_prod     = {r_acc, r_q};
    w_prod_fix = r_neg_q ? -w_prod : w_prod;
    if (r_op) begin
      // Quotient truncates toward zero; remainder follows the dividend's sign.
      w_fix_lo = r_neg_q ? -r_q : r_q;
      w_fix_hi = r_neg_r ? -r_acc : r_acc;
    end else begin
      w_fix_lo = w_prod_fix[WIDTH-1:0];
      w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_q        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_hi_we) r_hi <= i_wdata;
          if (i_lo_we) r_lo <= i_wdata;
          if (i_start) begin
            r_busy  <= 1'b1;
            r_op    <= i_op;
            r_neg_q <= i_is_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r <= i_is_signed & i_a[WIDTH-1];
            r_cnt   <= '0;
            if (i_op && w_b_zero) begin
              // Result load overrides a same-edge mthi/mtlo.
              r_hi       <= i_a;
              r_lo       <= '1;
              r_div_zero <= 1'b1;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_div_zero <= 1'b0;
              r_acc      <= '0;
              r_opnd     <= i_op ? w_b_mag : w_a_mag;
              r_q        <= i_op ? w_a_mag : w_b_mag;
              r_state    <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_next_acc;
          r_q   <= w_next_q;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_ITER) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_div_zero = r_div_zero;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;
  assign o_state    = r_state;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and HI/LO width; SHALL be >= 2.
REQ-002 Port: clock  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  request an operation; sampled only in IDLE.
REQ-005 Port: op  in  1  0 = multiply, 1 = divide; sampled with start.
REQ-006 Port: is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 Port: a  in  WIDTH  multiplicand / dividend; sampled with start.
REQ-008 Port: b  in  WIDTH  multiplier / divisor; sampled with start.
REQ-009 Port: hi_we  in  1  direct write of wdata into HI (mthi); honoured only in IDLE.
REQ-010 Port: lo_we  in  1  direct write of wdata into LO (mtlo); honoured only in IDLE.
REQ-011 Port: wdata  in  WIDTH  data for hi_we/lo_we.
REQ-012 Port: busy  out  1  high whenever state != IDLE.
REQ-013 Port: done  out  1  one-cycle pulse; HI/LO hold the new result in that cycle.
REQ-014 Port: div_zero  out  1  high with done when the last divide had b == 0; cleared on next accepted start.
REQ-015 Port: hi  out  WIDTH  HI register (product upper half / remainder).
REQ-016 Port: lo  out  WIDTH  LO register (product lower half / quotient).

Function
REQ-017 States SHALL be IDLE, CALC, FIX, DONE; all outputs registered.
REQ-018 IDLE & start & !(op & b==0): latch a, b, op, is_signed, load magnitudes (absolute values when is_signed), clear iteration counter, go to CALC.
REQ-019 IDLE & start & op & b==0: load HI=a, LO={WIDTH{1}}, set div_zero, go directly to DONE.
REQ-020 CALC SHALL perform exactly WIDTH iterations: radix-2 shift-add for multiply, radix-2 restoring shift-subtract for divide; after the WIDTH-th, go to FIX.
REQ-021 FIX SHALL apply sign correction (signed only), then load HI/LO and go to DONE; DONE asserts done and returns to IDLE next edge.
REQ-022 Latency: start high in cycle 0 -> done high in cycle WIDTH+2; div-by-zero -> done in cycle 1; busy high from cycle 1 through the done cycle.
REQ-023 Multiply: {HI,LO} = full 2*WIDTH-bit product, signed or unsigned per is_signed.
REQ-024 Divide: LO = quotient truncated toward zero; HI = remainder with sign of dividend (signed), so a == LO*b + HI.
REQ-025 Signed overflow case a = most-negative, b = -1: LO = most-negative (wrapped), HI = 0, div_zero = 0.
REQ-026 start, hi_we, lo_we SHALL be ignored while busy; changes on a/b/op/is_signed during busy SHALL not affect the result.
REQ-027 HI/LO SHALL hold their value except on a result load, an honoured hi_we/lo_we, or reset.
REQ-028 hi_we/lo_we in same IDLE cycle as start: write applies at that edge; the operation proceeds and its result later overwrites HI/LO. In the div-by-zero case the result load wins at the shared edge.
REQ-029 Iteration counter SHALL be clog2(WIDTH)+1 bits and never wrap within an operation.

Reset
REQ-030 reset high at any edge, including mid-CALC/FIX/DONE: state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0; in-flight operation discarded with no done pulse.
REQ-031 start asserted in the same cycle as reset SHALL be ignored.

Verification (WIDTH=32)
REQ-032 Unsigned mult a=0xFFFFFFFF, b=0xFFFFFFFF, start cycle 0 -> done cycle 34, hi=0xFFFFFFFE, lo=0x00000001, busy cycles 1-34.
REQ-033 Signed mult a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; same inputs unsigned -> hi=0x00000004, lo=0xFFFFFFF1.
REQ-034 Signed div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; unsigned a=7, b=2 -> lo=3, hi=1.
REQ-035 Div a=5, b=0 -> done cycle 1, div_zero=1, hi=5, lo=0xFFFFFFFF; signed a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 Reset in cycle 10 of a multiply -> next cycle busy=0, hi=lo=0, no done; start pulse in cycle 5 of an operation -> no effect, single done.
REQ-037 IDLE hi_we=1, wdata=0x1234 -> hi=0x1234 next cycle, lo unchanged; hi_we while busy -> hi unchanged.
